// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA framebuffer geometry and word/address types
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int PX_PER_WORD = 4;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / PX_PER_WORD;

  typedef logic [31:0] px_word_t;
  typedef logic [18:0] word_addr_t;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// rtl/fb_prefetch_fifo.sv - prefetch FIFO with flush and two combinational peek ports
module fb_prefetch_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          iVGA_CLK,
  input  logic          iRST,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic [31:0]   peek0,
  output logic [31:0]   peek1
);

  px_word_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr_nx;

  assign rd_ptr_nx = rd_ptr + 1'b1;
  assign peek0     = mem[rd_ptr];
  assign peek1     = mem[rd_ptr_nx];

  always_ff @(posedge iVGA_CLK) begin
    if (iRST || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // The issue rule bounds count+inflight, so these can only fire on a broken caller.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST && !flush) begin
      assert (!(push && !pop && count == (AW+1)'(DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/vga_fb_prefetch.sv
// rtl/vga_fb_prefetch.sv - framebuffer word prefetcher feeding the VGA scan with zero-latency reads
module vga_fb_prefetch
  import vga_pkg::*;
#(
  parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS,
  parameter int DEPTH       = 16,
  parameter int MEM_AW      = 24,
  parameter int BASE_WORD   = 0
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  input  logic [18:0]       iREAD_ADDR,
  output logic [31:0]       oREAD_DATA,
  output logic              oMEM_REQ,
  output logic [MEM_AW-1:0] oMEM_ADDR,
  input  logic              iMEM_ACK,
  input  logic              iMEM_RVALID,
  input  logic [31:0]       iMEM_RDATA,
  output logic              oUNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_addr_t    head_addr;
  word_addr_t    fetch_idx;
  word_addr_t    fetch_nx;
  word_addr_t    d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_nx;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nx;
  logic [CW:0]   budget_nx;
  logic [31:0]   peek0;
  logic [31:0]   peek1;
  logic          restart;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          miss;
  logic          req_nx;

  assign d       = iREAD_ADDR - head_addr;
  assign restart = (iREAD_ADDR == '0) && (head_addr != '0);
  assign xfer    = oMEM_REQ && iMEM_ACK;
  assign push    = iMEM_RVALID && (drop_cnt == '0) && !restart;
  assign pop     = (d == 19'd1) && (count != '0) && !restart;

  // An empty FIFO at d==0 is the frame-start fill window, not a miss; every
  // later starvation surfaces at the d==1 step before the head pops.
  assign miss = !restart && ((d > 19'd1) || ((d == 19'd1) && (count < CW'(2))));

  always_comb begin
    oREAD_DATA = '0;
    if ((d == 19'd0) && (count != '0)) begin
      oREAD_DATA = peek0;
    end else if ((d == 19'd1) && (count >= CW'(2))) begin
      oREAD_DATA = peek1;
    end
  end

  assign inflight_nx = inflight + {{AW{1'b0}}, xfer} - {{AW{1'b0}}, iMEM_RVALID};
  assign count_nx    = restart ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign fetch_nx    = restart ? '0 : fetch_idx + 19'(xfer);
  assign budget_nx   = {1'b0, count_nx} + {1'b0, inflight_nx};
  assign req_nx      = (fetch_nx < 19'(FRAME_WORDS)) && (budget_nx < (CW+1)'(DEPTH));

  // After a restart everything still outstanding belongs to the old scan.
  always_comb begin
    drop_nx = drop_cnt;
    if (restart) begin
      drop_nx = inflight_nx;
    end else if (iMEM_RVALID && (drop_cnt != '0)) begin
      drop_nx = drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      head_addr  <= '0;
      fetch_idx  <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      oMEM_REQ   <= 1'b0;
      oMEM_ADDR  <= MEM_AW'(BASE_WORD);
      oUNDERFLOW <= 1'b0;
    end else begin
      head_addr  <= restart ? '0 : head_addr + 19'(pop);
      fetch_idx  <= fetch_nx;
      inflight   <= inflight_nx;
      drop_cnt   <= drop_nx;
      oMEM_REQ   <= req_nx;
      oMEM_ADDR  <= MEM_AW'(BASE_WORD) + MEM_AW'(fetch_nx);
      oUNDERFLOW <= oUNDERFLOW | miss;
    end
  end

  fb_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .iVGA_CLK  (iVGA_CLK),
    .iRST      (iRST),
    .push      (push),
    .push_data (iMEM_RDATA),
    .pop       (pop),
    .flush     (restart),
    .count     (count),
    .peek0     (peek0),
    .peek1     (peek1)
  );

endmodule
